sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_pkg.sv | 8 +
 rtl/sram_fifo_outbuf.sv | 47 ++++
 rtl/sram_fifo_ctrl.sv | 90 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizing constants for the SRAM-backed FIFO.
// No ports; DEF_DEPTH/WIDTH/AW give the defaults, DEF_CW the count width.
package sram_fifo_pkg;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 7;
  localparam int DEF_CW    = DEF_AW + 1;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// sram_fifo_outbuf: 2-entry output buffer, head always at e0.
// Ports: clock, reset, push/push_data, pop, head, cnt (0..2).
module sram_fifo_outbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] e0, e1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // pop and push together: occupancy unchanged
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over an external 1-port SRAM + 2-entry ob.
// Ports: clock/reset, enq_* and deq_* handshakes, count, sram_* SRAM port.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [AW:0]      count,
  output logic [AW-1:0]    sram_a,
  output logic [WIDTH-1:0] sram_i,
  input  logic [WIDTH-1:0] sram_o,
  output logic             sram_csb,
  output logic             sram_web,
  output logic             sram_oeb
);
  localparam int CW = AW + 1;

  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      mem_cnt;
  logic             rd_pend;
  logic [1:0]       ob_cnt;
  logic             rd_issue, enq_fire, deq_fire;
  logic             bypass, wr_en, ob_push;
  logic [WIDTH-1:0] ob_din;

  // keep ob_cnt + rd_pend <= 2 so a capture always has room
  assign rd_issue = (mem_cnt != '0) &&
                    ((ob_cnt == 2'd0) ||
                     (ob_cnt == 2'd1 && !rd_pend));

  assign count = mem_cnt + CW'(rd_pend) + CW'(ob_cnt);

  assign enq_ready = !reset && !rd_issue &&
                     (count < CW'(DEPTH));
  assign deq_valid = (ob_cnt != 2'd0);

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  // skip the SRAM only when nothing older sits there or in flight
  assign bypass = enq_fire && (mem_cnt == '0) && !rd_pend &&
                  ((ob_cnt != 2'd2) || deq_fire);
  assign wr_en  = enq_fire && !bypass;

  // rd_pend excludes bypass, so one push source per cycle
  assign ob_push = rd_pend || bypass;
  assign ob_din  = rd_pend ? sram_o : enq_data;

  assign sram_csb = !(rd_issue || wr_en);
  assign sram_web = !wr_en;
  assign sram_oeb = !rd_issue;
  assign sram_a   = rd_issue ? rd_ptr : wr_ptr;
  assign sram_i   = enq_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      rd_pend <= rd_issue;
      mem_cnt <= mem_cnt + CW'(wr_en) - CW'(rd_issue);
    end
  end

  sram_fifo_outbuf #(
    .WIDTH(WIDTH)
  ) u_ob (
    .clock     (clock),
    .reset     (reset),
    .push      (ob_push),
    .push_data (ob_din),
    .pop       (deq_fire),
    .head      (deq_data),
    .cnt       (ob_cnt)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector table, scoreboard and corner sequences
// for sram_fifo_ctrl with a 1-cycle-latency SRAM model.
module tb_sram_fifo_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enq_valid = 1'b0;
  logic       enq_ready;
  logic [7:0] enq_data = 8'h00;
  logic       deq_valid;
  logic       deq_ready = 1'b0;
  logic [7:0] deq_data;
  logic [7:0] count;
  logic [6:0] sram_a;
  logic [7:0] sram_i;
  logic [7:0] sram_o = 8'h00;
  logic       sram_csb, sram_web, sram_oeb;

  int passes = 0;
  int total  = 0;

  sram_fifo_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_o    (sram_o),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [128];
  always @(posedge clock) begin
    if (!sram_csb && !sram_web) mem[sram_a] <= sram_i;
    if (!sram_csb && !sram_oeb) sram_o <= mem[sram_a];
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] q [$];
  int  wr_cnt = 0;
  int  pops = 0;
  bit  rd_d1 = 0, rd_d2 = 0;
  bit  wr_wrap = 0, rd_wrap = 0;
  int  last_wa = 0, last_ra = 0;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      rd_d1 = 0;
      rd_d2 = 0;
      last_wa = 0;
      last_ra = 0;
    end else begin
      chk("rw_excl", int'(!sram_csb && !sram_web && !sram_oeb), 0);
      chk("enq_on_rd", int'(!sram_oeb && enq_ready), 0);
      if (rd_d2) chk("rd_lat", int'(deq_valid), 1);
      rd_d2 = rd_d1;
      rd_d1 = !sram_csb && !sram_oeb;
      if (!sram_csb && !sram_web) begin
        wr_cnt++;
        if (last_wa == 127 && sram_a == 7'd0) wr_wrap = 1;
        last_wa = int'(sram_a);
      end
      if (!sram_csb && !sram_oeb) begin
        if (last_ra == 127 && sram_a == 7'd0) rd_wrap = 1;
        last_ra = int'(sram_a);
      end
      if (deq_valid && deq_ready) begin
        chk("sb_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) chk("sb_data", int'(deq_data), int'(q.pop_front()));
        pops++;
      end
      if (enq_valid && enq_ready) q.push_back(enq_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic enq_n(int n, int unsigned base, bit drv);
    int sent = 0;
    int cyc = 0;
    deq_ready = drv;
    enq_valid = 1'b1;
    enq_data = 8'(base);
    while (sent < n && cyc < 4 * n + 20) begin
      @(negedge clock);
      if (enq_ready) sent++;
      tick();
      enq_data = 8'(base + sent);
      cyc++;
    end
    enq_valid = 1'b0;
    chk("enq_done", sent, n);
  endtask

  task automatic drain();
    int cyc = 0;
    bit done = 0;
    deq_ready = 1'b1;
    enq_valid = 1'b0;
    while (!done && cyc < 600) begin
      @(negedge clock);
      if (count == 8'd0 && !deq_valid) done = 1;
      tick();
      cyc++;
    end
    @(negedge clock);
    chk("drain_count", int'(count), 0);
    chk("drain_dv", int'(deq_valid), 0);
    chk("drain_sb", q.size(), 0);
    tick();
  endtask

  typedef struct {
    logic       ev;
    logic [7:0] ed;
    logic       dr;
    logic       er;
    logic       dv;
    logic [7:0] dd;
    int         cnt;
    logic       csb;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    vt[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1, 1'b1};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1, 1'b1};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    vt[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    vt[5]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b1};
    vt[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 2, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 1, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1};

    // reset values, with enq_valid offered
    enq_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_er", int'(enq_ready), 0);
    chk("rst_dv", int'(deq_valid), 0);
    chk("rst_cnt", int'(count), 0);
    chk("rst_dd", int'(deq_data), 0);
    chk("rst_ctl", int'({sram_csb, sram_web, sram_oeb}), 7);
    tick();
    reset = 1'b0;
    enq_valid = 1'b0;

    // bypass and short SRAM round-trip table
    for (int i = 0; i < 12; i++) begin
      enq_valid = vt[i].ev;
      enq_data  = vt[i].ed;
      deq_ready = vt[i].dr;
      @(negedge clock);
      chk($sformatf("v%0d_er", i), int'(enq_ready), int'(vt[i].er));
      chk($sformatf("v%0d_dv", i), int'(deq_valid), int'(vt[i].dv));
      if (vt[i].dv)
        chk($sformatf("v%0d_dd", i), int'(deq_data), int'(vt[i].dd));
      chk($sformatf("v%0d_cnt", i), int'(count), vt[i].cnt);
      chk($sformatf("v%0d_csb", i), int'(sram_csb), int'(vt[i].csb));
      tick();
    end

    // fill to full, then offer one more
    do_reset();
    wr_cnt = 0;
    enq_n(128, 0, 1'b0);
    @(negedge clock);
    chk("full_cnt", int'(count), 128);
    chk("full_er", int'(enq_ready), 0);
    chk("full_wr", wr_cnt, 126);
    tick();
    enq_valid = 1'b1;
    enq_data = 8'hEE;
    repeat (3) begin
      @(negedge clock);
      chk("full_hold_er", int'(enq_ready), 0);
      chk("full_hold_cnt", int'(count), 128);
      tick();
    end
    enq_valid = 1'b0;
    pops = 0;
    drain();
    chk("drain_pops", pops, 128);

    // random traffic across the pointer wrap
    for (int c = 0; c < 300; c++) begin
      enq_valid = ($urandom_range(0, 9) < 7);
      enq_data  = 8'($urandom);
      deq_ready = ($urandom_range(0, 9) < 4);
      tick();
    end
    drain();
    chk("wr_wrap", int'(wr_wrap), 1);
    chk("rd_wrap", int'(rd_wrap), 1);

    // reset while a read is in flight
    do_reset();
    enq_n(3, 8'h10, 1'b0);
    deq_ready = 1'b1;
    begin
      bit found = 0;
      int cyc = 0;
      while (!found && cyc < 10) begin
        @(negedge clock);
        if (!sram_csb && !sram_oeb) found = 1;
        tick();
        cyc++;
      end
      chk("mid_rd_seen", int'(found), 1);
    end
    reset = 1'b1;
    #1;
    chk("mid_cnt", int'(count), 0);
    chk("mid_dv", int'(deq_valid), 0);
    chk("mid_er", int'(enq_ready), 0);
    chk("mid_ctl", int'({sram_csb, sram_web, sram_oeb}), 7);
    tick();
    tick();
    reset = 1'b0;
    enq_n(1, 8'h5A, 1'b1);
    begin
      bit got = 0;
      int cyc = 0;
      while (!got && cyc < 10) begin
        @(negedge clock);
        if (deq_valid) begin
          got = 1;
          chk("mid_5a", int'(deq_data), 8'h5A);
        end
        tick();
        cyc++;
      end
      chk("mid_5a_seen", int'(got), 1);
    end
    drain();

    // backpressure with ob full and SRAM non-empty
    do_reset();
    enq_n(10, 8'h80, 1'b0);
    begin
      logic [7:0] d = 8'h8A;
      enq_valid = 1'b1;
      enq_data = d;
      for (int c = 0; c < 40; c++) begin
        deq_ready = c[0];
        @(negedge clock);
        if (enq_ready) d = d + 8'd1;
        tick();
        enq_data = d;
      end
      enq_valid = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
